// File: rtl/i2c_target_byte_engine.sv
// Target-side I2C byte engine: synchronizes raw SCL/SDA, detects START/STOP, matches a
// 7-bit address, then receives or transmits bytes MSB-first with ACK/NACK handling.
module i2c_target_byte_engine #(
    parameter int         SYNC_STAGES  = 2,
    parameter int         ADDR_WIDTH   = 7,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_own_addr,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_sda_oe,
    input  logic [7:0]            i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_tx_underrun,
    output logic [7:0]            o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ack,
    output logic                  o_start_det,
    output logic                  o_stop_det,
    output logic                  o_addr_match,
    output logic                  o_rw,
    output logic                  o_busy
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_BYTE, ST_RX_ACK, ST_TX_BYTE, ST_TX_ACKCHK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic sda_oe_q, sda_oe_d, addr_match_q, addr_match_d, rw_q, rw_d, busy_q, busy_d;
    logic rx_valid_q, rx_valid_d, start_det_q, start_det_d, stop_det_q, stop_det_d;
    logic byte_done_q, byte_done_d, match_q, match_d, nack_q, nack_d;
    logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;
    logic load_tx, tx_ready, tx_underrun;
    logic [7:0] tx_byte;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_cond = scl_s & sda_prev_q & ~sda_s;
    assign stop_cond  = scl_s & ~sda_prev_q & sda_s;
    assign tx_byte    = i_tx_valid ? i_tx_data : IDLE_TX_BYTE;

    always_comb begin
        scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
        sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
        scl_prev_d   = scl_s;
        sda_prev_d   = sda_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        addr_match_d = addr_match_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        byte_done_d  = byte_done_q;
        match_d      = match_q;
        nack_d       = nack_q;
        rx_valid_d   = 1'b0;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;
        load_tx      = 1'b0;
        tx_ready     = 1'b0;
        tx_underrun  = 1'b0;

        if (state_q != ST_IDLE && scl_fall && !i_enable) begin
            sda_oe_d = 1'b0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                            match_d     = i_enable && (shift_q[6:0] == i_own_addr);
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (match_q) begin
                            sda_oe_d     = 1'b1;
                            addr_match_d = 1'b1;
                            rw_d         = shift_q[0];
                            state_d      = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (rw_q) load_tx = 1'b1;
                        else      state_d = ST_RX_BYTE;
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                            rx_data_d   = {shift_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = i_rx_ack;
                        nack_d      = ~i_rx_ack;
                        state_d     = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = nack_q ? ST_IDLE : ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    // Bit7 went out at the load edge; falls 1..7 shift out bits 6..0.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d    = 1'b0;
                            byte_done_d = 1'b0;
                            state_d     = ST_TX_ACKCHK;
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_TX_ACKCHK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d     = ST_IDLE;
                        else       byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        load_tx     = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load_tx) begin
            tx_ready    = 1'b1;
            tx_underrun = ~i_tx_valid;
            shift_d     = tx_byte;
            sda_oe_d    = ~tx_byte[7];
            state_d     = ST_TX_BYTE;
        end

        if (start_cond) begin
            state_d      = ST_ADDR;
            bit_cnt_d    = 3'd0;
            byte_done_d  = 1'b0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b1;
            start_det_d  = 1'b1;
        end else if (stop_cond) begin
            state_d      = ST_IDLE;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b0;
            stop_det_d   = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            sda_oe_q     <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            match_q      <= 1'b0;
            nack_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            byte_done_q  <= byte_done_d;
            match_q      <= match_d;
            nack_q       <= nack_d;
            rx_valid_q   <= rx_valid_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
        end
    end

    // Handshake strobes are combinational so ready and data capture share one cycle.
    assign o_tx_ready    = tx_ready;
    assign o_tx_underrun = tx_underrun;
    assign o_sda_oe      = sda_oe_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_start_det   = start_det_q;
    assign o_stop_det    = stop_det_q;
    assign o_addr_match  = addr_match_q;
    assign o_rw          = rw_q;
    assign o_busy        = busy_q;
endmodule
